sfx_mixer: RTL and testbench

SFX_MIXER -- requirements
Module: sfx_mixer

---
 rtl/sfx_pkg.sv | 27 ++
 rtl/sfx_mixer_if.sv | 19 +
 rtl/sfx_channel.sv | 93 +++++++++
 rtl/sfx_mixer.sv | 133 +++++++++++++
 tb/tb_sfx_mixer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types, defaults and saturation helper for the sound-effect mixer
package sfx_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_ADDR_W   = 15;
  localparam int DEF_CLK_DIV  = 6250;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ACCUM,
    ST_OUTPUT
  } state_e;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/sfx_mixer_if.sv
// rtl/sfx_mixer_if.sv - sample ROM bus and mixed audio output bundle
// master: mixer side (drives rom_addr/rom_rd, LData/RData/sample_valid; reads rom_data)
// slave : ROM/audio side (drives rom_data)
interface sfx_mixer_if
  import sfx_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ADDR_W   = DEF_ADDR_W
);
  logic [ADDR_W-1:0]   rom_addr;
  logic                rom_rd;
  logic [SAMPLE_W-1:0] rom_data;
  logic [SAMPLE_W-1:0] LData;
  logic [SAMPLE_W-1:0] RData;
  logic                sample_valid;

  modport master (output rom_addr, rom_rd, LData, RData, sample_valid, input rom_data);
  modport slave  (input rom_addr, rom_rd, LData, RData, sample_valid, output rom_data);
endinterface

// File: rtl/sfx_channel.sv
// rtl/sfx_channel.sv - one playback channel: pending trigger/stop, segment registers, offset walk
// Ports: Clk/Reset; trigger_i/stop_i pulses; loop_mode_i live; seg_start_i/seg_len_i captured
// with a trigger; apply_i commits pending requests; adv_i steps past the sample just read;
// busy_o channel active; addr_o current ROM address (base + offset, wrapping).
module sfx_channel
  import sfx_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              trigger_i,
  input  logic              stop_i,
  input  logic              loop_mode_i,
  input  logic [ADDR_W-1:0] seg_start_i,
  input  logic [ADDR_W-1:0] seg_len_i,
  input  logic              apply_i,
  input  logic              adv_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              busy_q, busy_d;
  logic              trig_pend_q, trig_pend_d;
  logic              stop_pend_q, stop_pend_d;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, off_q, off_d;
  logic [ADDR_W-1:0] base_pend_q, base_pend_d, len_pend_q, len_pend_d;

  always_comb begin
    busy_d      = busy_q;
    trig_pend_d = trig_pend_q;
    stop_pend_d = stop_pend_q;
    base_d      = base_q;
    len_d       = len_q;
    off_d       = off_q;
    base_pend_d = base_pend_q;
    len_pend_d  = len_pend_q;

    if (apply_i) begin
      trig_pend_d = 1'b0;
      stop_pend_d = 1'b0;
      if (stop_pend_q) begin
        busy_d = 1'b0;
      end else if (trig_pend_q) begin
        busy_d = 1'b1;
        off_d  = '0;
        base_d = base_pend_q;
        len_d  = len_pend_q;
      end
    end else if (adv_i && busy_q) begin
      if (off_q == len_q - ADDR_W'(1)) begin
        off_d = '0;
        if (!loop_mode_i) busy_d = 1'b0;
      end else begin
        off_d = off_q + ADDR_W'(1);
      end
    end

    // New pulses are latched after the commit so a pulse in the commit cycle is not lost.
    if (trigger_i && (seg_len_i != '0)) begin
      trig_pend_d = 1'b1;
      base_pend_d = seg_start_i;
      len_pend_d  = seg_len_i;
    end
    if (stop_i) stop_pend_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_q      <= 1'b0;
      trig_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      off_q       <= '0;
      base_pend_q <= '0;
      len_pend_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      trig_pend_q <= trig_pend_d;
      stop_pend_q <= stop_pend_d;
      base_q      <= base_d;
      len_q       <= len_d;
      off_q       <= off_d;
      base_pend_q <= base_pend_d;
      len_pend_q  <= len_pend_d;
    end
  end

  assign busy_o = busy_q;
  assign addr_o = base_q + off_q;

endmodule

// File: rtl/sfx_mixer.sv
// rtl/sfx_mixer.sv - multi-channel sound-effect mixer sharing one sample ROM
// Ports: Clk/Reset; trigger/stop/loop_mode per channel; seg_start/seg_len packed per channel;
// busy per channel; bus (master) carries rom_addr/rom_rd/rom_data and LData/RData/sample_valid.
module sfx_mixer
  import sfx_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CLK_DIV  = DEF_CLK_DIV
)(
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_CH-1:0]        trigger,
  input  logic [NUM_CH-1:0]        stop,
  input  logic [NUM_CH-1:0]        loop_mode,
  input  logic [NUM_CH*ADDR_W-1:0] seg_start,
  input  logic [NUM_CH*ADDR_W-1:0] seg_len,
  output logic [NUM_CH-1:0]        busy,
  sfx_mixer_if.master              bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
  localparam int DIV_W = $clog2(CLK_DIV);

  state_e                     state_q, state_d;
  logic [DIV_W-1:0]           cnt_q, cnt_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [SAMPLE_W-1:0]        ldata_q, ldata_d;
  logic                       sv_q, sv_d;
  logic                       rd_q, rd_d;
  logic                       rom_rd_c;
  logic [ADDR_W-1:0]          rom_addr_c;
  logic [NUM_CH-1:0]          adv;
  logic [ADDR_W-1:0]          ch_addr [NUM_CH];
  logic                       apply;

  // Pending channel requests are only committed between frames.
  assign apply = (state_q == ST_IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign adv[i] = (state_q == ST_FETCH) && (ch_q == CH_W'(i));
    sfx_channel #(.ADDR_W(ADDR_W)) u_ch (
      .Clk         (Clk),
      .Reset       (Reset),
      .trigger_i   (trigger[i]),
      .stop_i      (stop[i]),
      .loop_mode_i (loop_mode[i]),
      .seg_start_i (seg_start[i*ADDR_W +: ADDR_W]),
      .seg_len_i   (seg_len[i*ADDR_W +: ADDR_W]),
      .apply_i     (apply),
      .adv_i       (adv[i]),
      .busy_o      (busy[i]),
      .addr_o      (ch_addr[i])
    );
  end

  assign cnt_d = (cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : cnt_q + DIV_W'(1);

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    acc_d      = acc_q;
    ldata_d    = ldata_q;
    sv_d       = 1'b0;
    rom_rd_c   = 1'b0;
    rom_addr_c = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (cnt_q == '0) begin
          state_d = ST_FETCH;
          ch_d    = '0;
          acc_d   = '0;
        end
      end
      ST_FETCH: begin
        // Reset gates the strobe so an aborted frame issues no read in the reset cycle.
        if (busy[ch_q] && !Reset) begin
          rom_rd_c   = 1'b1;
          rom_addr_c = ch_addr[ch_q];
        end
        state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        // rd_q remembers whether the previous FETCH actually read; busy may have cleared since.
        if (rd_q) acc_d = acc_q + ACC_W'(signed'(bus.rom_data));
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          state_d = ST_OUTPUT;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_OUTPUT: begin
        ldata_d = SAMPLE_W'(sat_to_width(64'(acc_q), SAMPLE_W));
        sv_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_d = rom_rd_c;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      ldata_q <= '0;
      sv_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      ldata_q <= ldata_d;
      sv_q    <= sv_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.rom_rd       = rom_rd_c;
  assign bus.rom_addr     = rom_addr_c;
  assign bus.LData        = ldata_q;
  assign bus.RData        = ldata_q;
  assign bus.sample_valid = sv_q;

endmodule

// File: tb/tb_sfx_mixer.sv
// tb/tb_sfx_mixer.sv - self-checking bench for sfx_mixer with a frame-level reference model
module tb_sfx_mixer;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 15;
  localparam int CLK_DIV  = 20;
  localparam int LAT      = 2 * NUM_CH + 2;

  logic                     Clk = 1'b0;
  logic                     Reset = 1'b1;
  logic [NUM_CH-1:0]        trigger = '0;
  logic [NUM_CH-1:0]        stop = '0;
  logic [NUM_CH-1:0]        loop_mode = '0;
  logic [NUM_CH*ADDR_W-1:0] seg_start = '0;
  logic [NUM_CH*ADDR_W-1:0] seg_len = '0;
  logic [NUM_CH-1:0]        busy;

  sfx_mixer_if #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) bus ();

  sfx_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .trigger   (trigger),
    .stop      (stop),
    .loop_mode (loop_mode),
    .seg_start (seg_start),
    .seg_len   (seg_len),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // ROM contents: 0 = address itself, 1 = constant, 2 = random table
  int          rom_mode = 0;
  logic [15:0] rom_const = '0;
  logic [15:0] rom_rand [256];

  function automatic logic [15:0] rom_val(input logic [14:0] a);
    case (rom_mode)
      0:       return {1'b0, a};
      1:       return rom_const;
      default: return rom_rand[a[7:0]];
    endcase
  endfunction

  always @(posedge Clk) if (bus.rom_rd) bus.rom_data <= rom_val(bus.rom_addr);

  // Reference model: channel state advanced one whole frame at a time.
  bit m_busy [NUM_CH];
  int m_base [NUM_CH], m_len [NUM_CH], m_off [NUM_CH];
  bit m_tp [NUM_CH], m_sp [NUM_CH];
  int m_pb [NUM_CH], m_pl [NUM_CH];
  int cur_st [NUM_CH], cur_ln [NUM_CH];

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_busy[i] = 0; m_base[i] = 0; m_len[i] = 0; m_off[i] = 0;
      m_tp[i] = 0; m_sp[i] = 0; m_pb[i] = 0; m_pl[i] = 0;
    end
  endtask

  task automatic model_frame(output logic [15:0] exp);
    int sum;
    int a;
    logic [15:0] v;
    sum = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_sp[i]) m_busy[i] = 0;
      else if (m_tp[i]) begin
        m_busy[i] = 1; m_off[i] = 0; m_base[i] = m_pb[i]; m_len[i] = m_pl[i];
      end
      m_sp[i] = 0; m_tp[i] = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_busy[i]) begin
        a = (m_base[i] + m_off[i]) % 32768;
        v = rom_val(a[14:0]);
        sum += int'($signed(v));
        if (m_off[i] == m_len[i] - 1) begin
          m_off[i] = 0;
          if (!loop_mode[i]) m_busy[i] = 0;
        end else begin
          m_off[i]++;
        end
      end
    end
    if (sum > 32767) exp = 16'h7FFF;
    else if (sum < -32768) exp = 16'h8000;
    else exp = sum[15:0];
  endtask

  function automatic logic [NUM_CH-1:0] model_busy();
    logic [NUM_CH-1:0] b;
    for (int i = 0; i < NUM_CH; i++) b[i] = m_busy[i];
    return b;
  endfunction

  task automatic set_seg(input int ch, input int st, input int ln);
    seg_start[ch*ADDR_W +: ADDR_W] = ADDR_W'(st);
    seg_len[ch*ADDR_W +: ADDR_W]   = ADDR_W'(ln);
    cur_st[ch] = st;
    cur_ln[ch] = ln;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] t, input logic [NUM_CH-1:0] s);
    trigger = t;
    stop = s;
    for (int i = 0; i < NUM_CH; i++) begin
      if (t[i] && cur_ln[i] != 0) begin
        m_tp[i] = 1; m_pb[i] = cur_st[i]; m_pl[i] = cur_ln[i];
      end
      if (s[i]) m_sp[i] = 1;
    end
    @(posedge Clk); #1;
    trigger = '0;
    stop = '0;
  endtask

  task automatic wait_sv(output bit ok);
    ok = 0;
    for (int k = 0; k < CLK_DIV + 4 && !ok; k++) begin
      @(posedge Clk); #1;
      if (bus.sample_valid) ok = 1;
    end
  endtask

  task automatic test_reset();
    int lat;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    model_reset();
    vectors++;
    if ({bus.LData, bus.RData, bus.sample_valid, bus.rom_rd, bus.rom_addr, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: L=%h R=%h sv=%b rd=%b addr=%h busy=%b, required all 0",
               bus.LData, bus.RData, bus.sample_valid, bus.rom_rd, bus.rom_addr, busy);
    end
    Reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= LAT + 4 && lat < 0; k++) begin
      @(posedge Clk); #1;
      if (bus.sample_valid) lat = k;
    end
    vectors++;
    if (lat != LAT) begin
      miscompares++;
      $display("FAIL reset_latency: got %0d cycles, required %0d", lat, LAT);
    end
    vectors++;
    if (bus.LData !== 16'h0 || bus.RData !== 16'h0) begin
      miscompares++;
      $display("FAIL idle_frame: L=%h R=%h, required 0000", bus.LData, bus.RData);
    end
  endtask

  task automatic test_one_shot();
    logic [15:0] exp;
    bit ok;
    rom_mode = 0;
    loop_mode[0] = 1'b0;
    set_seg(0, 100, 3);
    pulse(4'b0001, 4'b0000);
    for (int f = 0; f < 4; f++) begin
      model_frame(exp);
      wait_sv(ok);
      vectors++;
      if (!ok || bus.LData !== exp || bus.RData !== exp || busy !== model_busy()) begin
        miscompares++;
        $display("FAIL one_shot f%0d: ok=%0b L=%h R=%h busy=%b, required %h busy=%b",
                 f, ok, bus.LData, bus.RData, busy, exp, model_busy());
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp;
    bit ok;
    rom_mode = 1;
    rom_const = 16'h7000;
    loop_mode = 4'b0011;
    set_seg(0, 0, 4);
    set_seg(1, 50, 4);
    pulse(4'b0011, 4'b0000);
    for (int f = 0; f < 7; f++) begin
      if (f == 3) rom_const = 16'h9000;
      if (f == 6) pulse(4'b0000, 4'b0011);
      model_frame(exp);
      wait_sv(ok);
      vectors++;
      if (!ok || bus.LData !== exp || bus.RData !== exp || busy !== model_busy()) begin
        miscompares++;
        $display("FAIL saturation f%0d: ok=%0b L=%h R=%h busy=%b, required %h busy=%b",
                 f, ok, bus.LData, bus.RData, busy, exp, model_busy());
      end
    end
  endtask

  task automatic test_loop_stop();
    logic [15:0] exp;
    bit ok;
    rom_mode = 0;
    loop_mode = 4'b0100;
    set_seg(2, 10, 2);
    pulse(4'b0100, 4'b0000);
    for (int f = 0; f < 6; f++) begin
      if (f == 5) pulse(4'b0000, 4'b0100);
      model_frame(exp);
      wait_sv(ok);
      vectors++;
      if (!ok || bus.LData !== exp || bus.RData !== exp || busy !== model_busy()) begin
        miscompares++;
        $display("FAIL loop_stop f%0d: ok=%0b L=%h R=%h busy=%b, required %h busy=%b",
                 f, ok, bus.LData, bus.RData, busy, exp, model_busy());
      end
    end
  endtask

  task automatic test_back_to_back_retrigger();
    logic [15:0] exp;
    bit ok;
    rom_mode = 0;
    loop_mode = 4'b1001;
    set_seg(3, 500, 3);
    set_seg(0, 200, 5);
    for (int f = 0; f < 5; f++) begin
      if (f == 0) pulse(4'b1000, 4'b1000);
      if (f == 1) pulse(4'b0001, 4'b0000);
      if (f == 3) begin
        set_seg(0, 300, 4);
        pulse(4'b0001, 4'b0000);
      end
      if (f == 4) pulse(4'b0000, 4'b0001);
      model_frame(exp);
      wait_sv(ok);
      vectors++;
      if (!ok || bus.LData !== exp || bus.RData !== exp || busy !== model_busy()) begin
        miscompares++;
        $display("FAIL retrigger f%0d: ok=%0b L=%h R=%h busy=%b, required %h busy=%b",
                 f, ok, bus.LData, bus.RData, busy, exp, model_busy());
      end
    end
  endtask

  task automatic test_len_zero_midframe();
    logic [15:0] exp;
    bit ok;
    rom_mode = 0;
    loop_mode = 4'b0000;
    set_seg(1, 700, 0);
    pulse(4'b0010, 4'b0000);
    model_frame(exp);
    wait_sv(ok);
    vectors++;
    if (!ok || bus.LData !== exp || busy !== model_busy()) begin
      miscompares++;
      $display("FAIL len_zero: ok=%0b L=%h busy=%b, required %h busy=%b",
               ok, bus.LData, busy, exp, model_busy());
    end
    // Land two cycles into the next frame (a FETCH/ACCUM cycle) before triggering.
    set_seg(1, 40, 3);
    repeat (12) @(posedge Clk);
    #1;
    model_frame(exp);
    pulse(4'b0010, 4'b0000);
    for (int f = 0; f < 4; f++) begin
      if (f > 0) model_frame(exp);
      wait_sv(ok);
      vectors++;
      if (!ok || bus.LData !== exp || bus.RData !== exp || busy !== model_busy()) begin
        miscompares++;
        $display("FAIL midframe_trig f%0d: ok=%0b L=%h R=%h busy=%b, required %h busy=%b",
                 f, ok, bus.LData, bus.RData, busy, exp, model_busy());
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    logic [NUM_CH-1:0] t, s;
    bit ok;
    for (int i = 0; i < 256; i++) rom_rand[i] = 16'($urandom);
    rom_mode = 2;
    for (int f = 0; f < 40; f++) begin
      loop_mode = NUM_CH'($urandom);
      t = NUM_CH'($urandom);
      s = NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 3) == 0) set_seg(i, int'($urandom_range(32760, 32767)), int'($urandom_range(0, 6)));
        else set_seg(i, int'($urandom_range(0, 32767)), int'($urandom_range(0, 6)));
      end
      pulse(t, s);
      model_frame(exp);
      wait_sv(ok);
      vectors++;
      if (!ok || bus.LData !== exp || bus.RData !== exp || busy !== model_busy()) begin
        miscompares++;
        $display("FAIL random f%0d: ok=%0b L=%h R=%h busy=%b, required %h busy=%b",
                 f, ok, bus.LData, bus.RData, busy, exp, model_busy());
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] exp;
    logic [14:0] exp_addr;
    int a;
    int lat;
    bit ok;
    bit sv_seen;
    rom_mode = 0;
    loop_mode = 4'b1111;
    set_seg(0, 1000, 4);
    pulse(4'b0001, 4'b0000);
    model_frame(exp);
    wait_sv(ok);
    vectors++;
    if (!ok || bus.LData !== exp) begin
      miscompares++;
      $display("FAIL pre_reset_frame: ok=%0b L=%h, required %h", ok, bus.LData, exp);
    end
    repeat (11) @(posedge Clk);
    #1;
    a = (m_base[0] + m_off[0]) % 32768;
    exp_addr = a[14:0];
    vectors++;
    if (bus.rom_rd !== 1'b1 || bus.rom_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL fetch_ch0: rd=%b addr=%0d, required rd=1 addr=%0d", bus.rom_rd, bus.rom_addr, exp_addr);
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    sv_seen = bus.sample_valid;
    @(posedge Clk); #1;
    sv_seen = sv_seen | bus.sample_valid;
    model_reset();
    vectors++;
    if (sv_seen || {bus.LData, bus.RData, bus.rom_rd, bus.rom_addr, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_midframe: sv_seen=%0b L=%h R=%h rd=%b addr=%h busy=%b, required all 0",
               sv_seen, bus.LData, bus.RData, bus.rom_rd, bus.rom_addr, busy);
    end
    Reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= LAT + 4 && lat < 0; k++) begin
      @(posedge Clk); #1;
      if (bus.sample_valid) lat = k;
    end
    vectors++;
    if (lat != LAT || bus.LData !== 16'h0) begin
      miscompares++;
      $display("FAIL post_reset_latency: got %0d cycles L=%h, required %0d cycles L=0000", lat, bus.LData, LAT);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      cur_st[i] = 0;
      cur_ln[i] = 0;
    end
    test_reset();
    test_one_shot();
    test_saturation();
    test_loop_stop();
    test_back_to_back_retrigger();
    test_len_zero_midframe();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
